// File: rtl/stream_mux_rr.sv
// N-input packet-aware stream mux: round-robin or fixed-priority arbitration,
// packet lock until the last beat, single registered output stage.
module stream_mux_rr #(
  parameter int unsigned N_INPUTS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned SEL_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]            in_valid,
  input  logic [N_INPUTS-1:0]            in_last,
  output logic [N_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [SEL_WIDTH-1:0]           out_sel,
  input  logic                           out_ready
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  lock_q, lock_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;

  logic                 slot_free;
  logic                 grant_valid;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] cand;
  logic [SEL_WIDTH-1:0] acc_idx;
  logic                 accept;

  assign slot_free = !valid_q || out_ready;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = int'(N_INPUTS); k >= 1; k--) begin
      if (ARB_MODE == 1) begin
        cand = SEL_WIDTH'(k - 1);
      end else begin
        cand = SEL_WIDTH'((32'(rr_ptr_q) + 32'(k)) % N_INPUTS);
      end
      if (in_valid[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && slot_free) begin
      if (state_q == StLocked) begin
        in_ready[lock_q] = 1'b1;
      end else if (grant_valid) begin
        in_ready[grant] = 1'b1;
      end
    end
  end

  assign acc_idx = (state_q == StLocked) ? lock_q : grant;
  assign accept  = |(in_valid & in_ready);

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    sel_d    = sel_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data[32'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
      last_d  = in_last[acc_idx];
      sel_d   = acc_idx;
      if (in_last[acc_idx]) begin
        state_d  = StIdle;
        rr_ptr_d = acc_idx;
      end else begin
        state_d = StLocked;
        lock_d  = acc_idx;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // rr_ptr resets to the last index so channel 0 is the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lock_q   <= '0;
      rr_ptr_q <= SEL_WIDTH'(N_INPUTS - 1);
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: three instances (RR N=4, fixed-priority N=4, RR N=3)
// driven by directed and random stimulus, checked against a packet-level reference model.
module tb_stream_mux_rr;

  localparam int ND = 3;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  vld  [ND];
  logic [3:0]  lst  [ND];
  logic [31:0] dat  [ND];
  logic        ordy [ND];
  logic [7:0]  odat [ND];
  logic        oval [ND];
  logic        olst [ND];
  logic [1:0]  osel [ND];
  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy3;

  int n_ch [ND] = '{4, 4, 3};
  int mode [ND] = '{0, 1, 0};

  // Reference model state: register occupancy, packet owner, last-served channel.
  bit         m_full [ND];
  bit         m_lock [ND];
  int         m_own  [ND];
  int         m_rr   [ND];
  logic [3:0] m_acc  [ND];
  beat_t      sb     [ND][$];
  beat_t      lg     [ND][$];

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0]), .in_valid(vld[0]), .in_last(lst[0]),
    .in_ready(rdy0), .out_data(odat[0]), .out_valid(oval[0]), .out_last(olst[0]),
    .out_sel(osel[0]), .out_ready(ordy[0]));

  stream_mux_rr #(.N_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(1)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1]), .in_valid(vld[1]), .in_last(lst[1]),
    .in_ready(rdy1), .out_data(odat[1]), .out_valid(oval[1]), .out_last(olst[1]),
    .out_sel(osel[1]), .out_ready(ordy[1]));

  stream_mux_rr #(.N_INPUTS(3), .DATA_WIDTH(8), .ARB_MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[2][23:0]), .in_valid(vld[2][2:0]),
    .in_last(lst[2][2:0]), .in_ready(rdy3), .out_data(odat[2]), .out_valid(oval[2]),
    .out_last(olst[2]), .out_sel(osel[2]), .out_ready(ordy[2]));

  function automatic logic [3:0] rdy_of(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      default: return {1'b0, rdy3};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset(input int d);
    m_full[d] = 1'b0;
    m_lock[d] = 1'b0;
    m_own[d]  = 0;
    m_rr[d]   = n_ch[d] - 1;
    m_acc[d]  = '0;
    sb[d].delete();
  endtask

  // Packet-level arbitration: owner keeps the output until its last beat; otherwise
  // the first valid channel in search order wins when the output slot can take a beat.
  task automatic model_step(input int d);
    logic [3:0] er;
    int         g;
    bit         sf;
    er       = '0;
    g        = -1;
    m_acc[d] = '0;
    if (!rst_n) begin
      chk($sformatf("in_ready_rst[%0d]", d), rdy_of(d), 0);
      return;
    end
    sf = !m_full[d] || ordy[d];
    if (m_lock[d]) begin
      g = m_own[d];
    end else begin
      for (int k = 1; k <= n_ch[d]; k++) begin
        int c;
        c = (mode[d] == 1) ? k - 1 : (m_rr[d] + k) % n_ch[d];
        if (vld[d][c]) begin
          g = c;
          break;
        end
      end
    end
    if (sf && g >= 0) er[g] = 1'b1;
    chk($sformatf("in_ready[%0d]", d), rdy_of(d), er);
    if (g >= 0 && er[g] && vld[d][g]) begin
      m_acc[d][g] = 1'b1;
      sb[d].push_back('{sel: 2'(g), data: dat[d][g*8 +: 8], last: lst[d][g]});
      m_full[d] = 1'b1;
      if (lst[d][g]) begin
        m_lock[d] = 1'b0;
        m_rr[d]   = g;
      end else begin
        m_lock[d] = 1'b1;
        m_own[d]  = g;
      end
    end else if (ordy[d]) begin
      m_full[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) model_step(d);
  end

  // Monitor: compare the presented beat with the scoreboard head, log consumed beats.
  always @(posedge clk) begin
    beat_t e;
    #3;
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("out_valid[%0d]", d), oval[d], m_full[d]);
        if (oval[d] && m_full[d] && sb[d].size() > 0) begin
          e = sb[d][0];
          chk($sformatf("out_data[%0d]", d), odat[d], e.data);
          chk($sformatf("out_sel[%0d]", d), osel[d], e.sel);
          chk($sformatf("out_last[%0d]", d), olst[d], e.last);
          if (ordy[d]) begin
            lg[d].push_back('{sel: osel[d], data: odat[d], last: olst[d]});
            sb[d].delete(0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < ND; d++) lg[d].delete();
  endtask

  task automatic idle_all(input int cycles);
    for (int d = 0; d < ND; d++) begin
      vld[d]  = '0;
      ordy[d] = 1'b1;
    end
    repeat (cycles) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bt, cyc, stall;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      vld[d]  = 4'hF;
      lst[d]  = 4'hF;
      dat[d]  = 32'h1312_1110;
      ordy[d] = 1'b1;
      model_reset(d);
    end
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), oval[d], 0);
      chk($sformatf("rst_out_data[%0d]", d), odat[d], 0);
      chk($sformatf("rst_out_sel[%0d]", d), osel[d], 0);
      chk($sformatf("rst_out_last[%0d]", d), olst[d], 0);
    end

    // Round-robin fairness with all channels streaming single-beat packets.
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rr_log_size", 32'(lg[0].size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_order_sel_%0d", i), lg[0][i].sel, i % 4);
      chk($sformatf("rr_order_data_%0d", i), lg[0][i].data, 8'h10 + 8'(i % 4));
    end
    idle_all(3);
    clear_logs();

    // Packet lock: 3-beat packet on channel 1 while channel 0 keeps requesting.
    vld[0] = 4'b0010;
    lst[0] = 4'b0000;
    dat[0] = 32'h0000_A055;
    bt = 0;
    cyc = 0;
    while (bt < 3 && cyc < 40) begin
      step();
      cyc++;
      if (m_acc[0][1]) bt++;
      vld[0][0] = 1'b1;
      lst[0][0] = 1'b1;
      if (bt < 3) begin
        dat[0][15:8] = 8'hA0 + 8'(bt);
        lst[0][1]    = (bt == 2);
      end else begin
        vld[0][1] = 1'b0;
      end
    end
    chk("lock_pkt_done", bt, 3);
    repeat (3) step();
    idle_all(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lock_data_%0d", i), lg[0][i].data, 8'hA0 + 8'(i));
      chk($sformatf("lock_sel_%0d", i), lg[0][i].sel, 1);
      chk($sformatf("lock_last_%0d", i), lg[0][i].last, (i == 2) ? 1 : 0);
    end
    chk("lock_then_ch0_sel", lg[0][3].sel, 0);
    chk("lock_then_ch0_data", lg[0][3].data, 8'h55);
    clear_logs();

    // Backpressure: 5-cycle stall in the middle of a 4-beat packet on channel 2.
    vld[0] = 4'b1100;
    lst[0] = 4'b1000;
    dat[0] = 32'h77B0_0000;
    bt = 0;
    cyc = 0;
    stall = 0;
    while (bt < 4 && cyc < 60) begin
      step();
      cyc++;
      if (m_acc[0][2]) bt++;
      if (bt == 2 && stall < 5) begin
        ordy[0] = 1'b0;
        stall++;
      end else begin
        ordy[0] = 1'b1;
      end
      if (bt < 4) begin
        dat[0][23:16] = 8'hB0 + 8'(bt);
        lst[0][2]     = (bt == 3);
      end else begin
        vld[0][2] = 1'b0;
      end
    end
    chk("bp_pkt_done", bt, 4);
    chk("bp_stall_cycles", stall, 5);
    repeat (3) step();
    idle_all(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_data_%0d", i), lg[0][i].data, 8'hB0 + 8'(i));
      chk($sformatf("bp_sel_%0d", i), lg[0][i].sel, 2);
    end
    chk("bp_next_sel", lg[0][4].sel, 3);
    chk("bp_next_data", lg[0][4].data, 8'h77);
    clear_logs();

    // Fixed priority: channel 2 beats channel 3 until it drops valid.
    vld[1] = 4'b1100;
    lst[1] = 4'hF;
    dat[1] = 32'h3322_1100;
    repeat (6) step();
    vld[1][2] = 1'b0;
    repeat (3) step();
    idle_all(3);
    chk("fp_log_size", lg[1].size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fp_sel_%0d", i), lg[1][i].sel, (i < 6) ? 2 : 3);
    end
    clear_logs();

    // Reset mid-packet on the N=3 instance, then check wrap-around order.
    vld[2] = 4'b0100;
    lst[2] = 4'b0000;
    dat[2] = 32'h00C0_0000;
    cyc = 0;
    while (!m_acc[2][2] && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rst_mid_first_beat", m_acc[2][2], 1);
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) model_reset(d);
    vld[2] = 4'b0111;
    lst[2] = 4'b0111;
    dat[2] = 32'h0022_2120;
    #1;
    chk("rst_mid_out_valid", oval[2], 0);
    chk("rst_mid_out_data", odat[2], 0);
    chk("rst_mid_out_sel", osel[2], 0);
    chk("rst_mid_out_last", olst[2], 0);
    chk("rst_mid_in_ready", rdy3, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    idle_all(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_sel_%0d", i), lg[2][i].sel, i % 3);
      chk($sformatf("wrap_data_%0d", i), lg[2][i].data, 8'h20 + 8'(i % 3));
    end
    clear_logs();

    // Randomised traffic on all instances.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < ND; d++) begin
        vld[d]  = 4'($urandom) & ((n_ch[d] == 4) ? 4'hF : 4'h7);
        lst[d]  = 4'($urandom);
        dat[d]  = $urandom;
        ordy[d] = ($urandom_range(3) != 0);
      end
      step();
    end
    idle_all(4);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("drain_empty[%0d]", d), sb[d].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
